scan_receive: RTL and testbench
===============================

Name: scan_receive

Overview:
Receive-side counterpart of the board scan transmitter. It consumes bytes from the UART receiver and reassembles one full board scan. A scan is 10 rows, and each row arrives as a left-half byte followed by a right-half byte, each carrying 5 piece bits. Once all 20 bytes are in, it publishes a 100-bit occupancy map in a single update. Used for loopback self-test of the scan path and for accepting a board image from the host.

Parameters:
ROWS, 10, number of rows per scan frame
TIMEOUT_CYCLES, 24'd5000000, maximum idle clocks between consecutive bytes of a frame (100 ms at 50 MHz)
TAG, 2'b10, required value of byte bits [7:6] for a scan byte

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
arm  input  1  one-cycle pulse; begin (or restart) reception of a frame
rx_data_ready  input  1  one-cycle strobe from UART receiver; rx_data valid this cycle
rx_data  input  8  received byte: [7:6] tag, [5] half (0 = left, 1 = right), [4:0] pieces
board  output  100  last complete frame; bit (r*10 + c) is row r (0..9), column c (0..9)
row_count  output  4  rows fully received in the current frame (0..10)
busy  output  1  high while a frame is being received
frame_done  output  1  one-cycle pulse when board is updated
frame_error  output  1  one-cycle pulse when a frame is aborted
LEDG  output  8  debug: {busy, last_error_code[2:0], row_count}

Behaviour:
- Reset (synchronous, active-high; clk rising edge with reset=1):
  - board=0, row_count=0, busy=0, frame_done=0, frame_error=0, last_error_code=0, state=IDLE.
  - The shadow buffer and timeout counter are cleared.
  - Reset mid-frame discards all partial data.
- States: IDLE, WAIT_LEFT, WAIT_RIGHT.
  - busy=1 exactly in WAIT_LEFT and WAIT_RIGHT.
- IDLE:
  - rx_data_ready is ignored.
  - arm -> WAIT_LEFT; row_count=0, shadow=0, timer=0.
- WAIT_LEFT, on rx_data_ready with tag==TAG and half==0:
  - shadow[row*10+4 : row*10] <= rx_data[4:0], where row = row_count.
  - Go to WAIT_RIGHT; timer=0.
- WAIT_RIGHT, on rx_data_ready with tag==TAG and half==1:
  - shadow[row*10+9 : row*10+5] <= rx_data[4:0]; row_count increments; timer=0.
  - If the new row_count==ROWS: board <= completed shadow (including this byte), frame_done=1 on the next cycle, go to IDLE. row_count holds at 10 until the next arm.
  - Otherwise go to WAIT_LEFT.
- Column mapping: pieces bit k maps to column k (left byte) or column 5+k (right byte).
- Errors (all abort to IDLE, pulse frame_error for one cycle, leave board unchanged, set last_error_code):
  - tag!=TAG -> code 1.
  - Wrong half for the current state -> code 2.
  - Timer reaches TIMEOUT_CYCLES while busy -> code 3.
- Timer: counts every cycle while busy and resets on each accepted byte. The timeout error fires in the cycle the count equals TIMEOUT_CYCLES.
- Priority within a cycle: reset > arm > rx_data_ready > timeout.
  - arm while busy restarts the frame: row_count=0, shadow cleared, no error pulse. Any byte strobed in the same cycle is discarded.
  - A byte arriving in the same cycle the timeout would fire is accepted, and no timeout occurs.
- Latency: frame_done asserts 1 cycle after the strobe of the 20th byte; board is valid in that same cycle.
- frame_done and frame_error are never high together. Each is high for at most 1 cycle per frame.
- last_error_code is cleared by arm.

Test Plan:
- Happy path: reset, arm, then 20 bytes with row r left=0x80|r[4:0] and right=0xA0|(~r)[4:0] -> frame_done pulses once, 1 cycle after byte 20; board row r = {~r[4:0], r[4:0]}; row_count=10; busy=0.
- Bad tag: arm, send 0x81, then 0x41 -> frame_error pulses once; LEDG[6:4]=1; board still equals the previous frame; busy=0.
- Half order: arm, then 0xA3 as the first byte -> frame_error with code 2. A following arm plus a valid frame -> frame_done.
- Timeout (TIMEOUT_CYCLES=100): arm, send 3 bytes, then idle -> frame_error exactly 100 cycles after the last strobe. A byte strobed at cycle 99 instead -> no error.
- Restart and simultaneity: mid-frame at row_count=4, assert arm together with rx_data_ready=0x85 -> row_count=0, no error, byte ignored. The next 20 valid bytes produce frame_done.
- Reset mid-frame: after 7 bytes, pulse reset -> all outputs 0. Bytes sent while IDLE are ignored; board stays 0.

Source files
------------

// File: rtl/scan_receive.sv
`default_nettype none
// ============================================================================
// Module      : scan_receive
// Description : Reassembles one board scan from UART bytes. Each row is a
//               left-half byte then a right-half byte carrying 5 piece bits
//               each. The 100-bit occupancy map is published in one update
//               once all rows are in. Tag, half-order and inter-byte timeout
//               errors abort the frame without touching the published board.
// Revision    : 1.0  initial release
// ============================================================================
module scan_receive #(
    parameter int unsigned ROWS           = 10,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd5000000,
    parameter logic [1:0]  TAG            = 2'b10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arm,
    input  logic                 rx_data_ready,
    input  logic [7:0]           rx_data,
    output logic [ROWS*10-1:0]   board,
    output logic [3:0]           row_count,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 frame_error,
    output logic [7:0]           LEDG
);

    localparam int unsigned c_BITS  = ROWS * 10;
    localparam int unsigned c_IDX_W = $clog2(c_BITS);
    localparam logic [3:0]  c_ROWS  = 4'(ROWS);

    localparam logic [2:0] c_ERR_TAG     = 3'd1;
    localparam logic [2:0] c_ERR_HALF    = 3'd2;
    localparam logic [2:0] c_ERR_TIMEOUT = 3'd3;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_LEFT  = 2'd1,
        S_WAIT_RIGHT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [3:0]          r_row_count;
    logic [3:0]          w_row_next;
    logic [c_BITS-1:0]   r_shadow;
    logic [c_BITS-1:0]   w_shadow_next;
    logic [c_BITS-1:0]   r_board;
    logic [c_BITS-1:0]   w_board_next;
    logic [23:0]         r_timer;
    logic [23:0]         w_timer_next;
    logic                r_frame_done;
    logic                w_done_next;
    logic                r_frame_error;
    logic                w_error_next;
    logic [2:0]          r_last_error_code;
    logic [2:0]          w_code_next;

    logic [23:0]         w_timer_inc;
    logic [c_IDX_W-1:0]  w_base;
    logic [c_IDX_W-1:0]  w_base_right;
    logic [3:0]          w_row_inc;
    logic                w_tag_ok;
    logic                w_half;

    // Byte field decode and per-row bit offsets into the shadow buffer.
    assign w_tag_ok     = (rx_data[7:6] == TAG);
    assign w_half       = rx_data[5];
    assign w_base       = c_IDX_W'(r_row_count) * c_IDX_W'(10);
    assign w_base_right = w_base + c_IDX_W'(5);
    assign w_row_inc    = r_row_count + 4'd1;
    // The timer value this cycle would reach; timeout fires when it hits the limit.
    assign w_timer_inc  = r_timer + 24'd1;

    // Next-state and datapath decisions: arm beats a byte, a byte beats timeout.
    always_comb begin
        w_state_next  = r_state;
        w_row_next    = r_row_count;
        w_shadow_next = r_shadow;
        w_board_next  = r_board;
        w_timer_next  = r_timer;
        w_done_next   = 1'b0;
        w_error_next  = 1'b0;
        w_code_next   = r_last_error_code;

        if (arm) begin
            // Start or restart; any byte strobed alongside is dropped.
            w_state_next  = S_WAIT_LEFT;
            w_row_next    = 4'd0;
            w_shadow_next = '0;
            w_timer_next  = 24'd0;
            w_code_next   = 3'd0;
        end else if (r_state != S_IDLE) begin
            if (rx_data_ready) begin
                if (!w_tag_ok) begin
                    w_state_next = S_IDLE;
                    w_error_next = 1'b1;
                    w_code_next  = c_ERR_TAG;
                    w_timer_next = 24'd0;
                end else if (w_half != (r_state == S_WAIT_RIGHT)) begin
                    w_state_next = S_IDLE;
                    w_error_next = 1'b1;
                    w_code_next  = c_ERR_HALF;
                    w_timer_next = 24'd0;
                end else if (r_state == S_WAIT_LEFT) begin
                    w_shadow_next[w_base +: 5] = rx_data[4:0];
                    w_state_next               = S_WAIT_RIGHT;
                    w_timer_next               = 24'd0;
                end else begin
                    w_shadow_next[w_base_right +: 5] = rx_data[4:0];
                    w_row_next                       = w_row_inc;
                    w_timer_next                     = 24'd0;
                    if (w_row_inc == c_ROWS) begin
                        // Publish including the byte that just arrived.
                        w_board_next = w_shadow_next;
                        w_done_next  = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_WAIT_LEFT;
                    end
                end
            end else if (w_timer_inc == TIMEOUT_CYCLES) begin
                w_state_next = S_IDLE;
                w_error_next = 1'b1;
                w_code_next  = c_ERR_TIMEOUT;
                w_timer_next = 24'd0;
            end else begin
                w_timer_next = w_timer_inc;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath registers: partial frame, published board, timer and pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_row_count       <= 4'd0;
            r_shadow          <= '0;
            r_board           <= '0;
            r_timer           <= 24'd0;
            r_frame_done      <= 1'b0;
            r_frame_error     <= 1'b0;
            r_last_error_code <= 3'd0;
        end else begin
            r_row_count       <= w_row_next;
            r_shadow          <= w_shadow_next;
            r_board           <= w_board_next;
            r_timer           <= w_timer_next;
            r_frame_done      <= w_done_next;
            r_frame_error     <= w_error_next;
            r_last_error_code <= w_code_next;
        end
    end

    assign board       = r_board;
    assign row_count   = r_row_count;
    assign busy        = (r_state != S_IDLE);
    assign frame_done  = r_frame_done;
    assign frame_error = r_frame_error;
    assign LEDG        = {busy, r_last_error_code, r_row_count};

endmodule
`default_nettype wire

// File: tb/tb_scan_receive.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_receive
// Description : Randomised self-checking bench for scan_receive. A frame-level
//               model predicts every done/error pulse into a queue; a negedge
//               monitor pops and compares when the DUT pulses.
// Revision    : 1.0  initial release
// ============================================================================
module tb_scan_receive;

    localparam int TMO = 100;

    logic        clk;
    logic        reset;
    logic        arm;
    logic        rx_data_ready;
    logic [7:0]  rx_data;
    logic [99:0] board;
    logic [3:0]  row_count;
    logic        busy;
    logic        frame_done;
    logic        frame_error;
    logic [7:0]  LEDG;

    scan_receive #(
        .ROWS           (10),
        .TIMEOUT_CYCLES (24'd100),
        .TAG            (2'b10)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .arm           (arm),
        .rx_data_ready (rx_data_ready),
        .rx_data       (rx_data),
        .board         (board),
        .row_count     (row_count),
        .busy          (busy),
        .frame_done    (frame_done),
        .frame_error   (frame_error),
        .LEDG          (LEDG)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int n     = 0;   // number of rising edges so far

    typedef struct {
        bit          is_err;
        int          cyc;
        logic [2:0]  code;
        logic [99:0] brd;
    } ev_t;
    ev_t exp_q[$];

    // Frame-level reference state
    bit          m_active = 0;
    int          m_bytes  = 0;
    logic [3:0]  m_rows   = 0;
    logic [2:0]  m_code   = 0;
    logic [99:0] m_board  = '0;
    int          m_last   = 0;
    logic [4:0]  m_left  [10];
    logic [4:0]  m_right [10];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, n, act, exp);
        end
    endtask

    task automatic m_abort(input logic [2:0] code);
        ev_t e;
        m_active = 0;
        m_code   = code;
        e.is_err = 1; e.cyc = n; e.code = code; e.brd = m_board;
        exp_q.push_back(e);
    endtask

    // Frame-level model applied for the edge just taken.
    task automatic model(input logic a_reset, input logic a_arm, input logic a_rdy, input logic [7:0] d);
        ev_t e;
        int  r;
        if (a_reset) begin
            m_active = 0; m_bytes = 0; m_rows = 0; m_code = 0; m_board = '0;
        end else if (a_arm) begin
            m_active = 1; m_bytes = 0; m_rows = 0; m_code = 0; m_last = n;
        end else if (m_active) begin
            if (a_rdy) begin
                if (d[7:6] != 2'b10) m_abort(3'd1);
                else if (int'(d[5]) != (m_bytes % 2)) m_abort(3'd2);
                else begin
                    r = m_bytes / 2;
                    if (d[5] == 1'b0) m_left[r] = d[4:0];
                    else              m_right[r] = d[4:0];
                    m_bytes++;
                    m_rows = 4'(m_bytes / 2);
                    m_last = n;
                    if (m_bytes == 20) begin
                        for (int row = 0; row < 10; row++)
                            for (int c = 0; c < 10; c++)
                                m_board[row*10 + c] = (c < 5) ? m_left[row][c] : m_right[row][c-5];
                        m_active = 0;
                        e.is_err = 0; e.cyc = n; e.code = m_code; e.brd = m_board;
                        exp_q.push_back(e);
                    end
                end
            end else if (n - m_last == TMO) begin
                m_abort(3'd3);
            end
        end
    endtask

    // One clock: drive, take the edge, update the model, check steady outputs.
    task automatic step(input logic a_reset, input logic a_arm, input logic a_rdy, input logic [7:0] d);
        reset = a_reset; arm = a_arm; rx_data_ready = a_rdy; rx_data = d;
        @(posedge clk);
        n++;
        model(a_reset, a_arm, a_rdy, d);
        @(negedge clk);
        check("busy", 128'(busy), 128'(m_active));
        check("row_count", 128'(row_count), 128'(m_rows));
        check("ledg", 128'(LEDG), 128'({m_active, m_code, m_rows}));
        check("board", 128'(board), 128'(m_board));
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 8'h00);
    endtask

    task automatic send(input logic [7:0] d);
        step(0, 0, 1, d);
    endtask

    task automatic send_pattern_frame();
        for (int r = 0; r < 10; r++) begin
            logic [4:0] rv;
            rv = 5'(r);
            send({3'b100, rv});
            idle(int'($urandom_range(0, 2)));
            send({3'b101, ~rv});
            idle(int'($urandom_range(0, 2)));
        end
    endtask

    task automatic send_random_frame();
        for (int b = 0; b < 20; b++) begin
            send({2'b10, 1'(b % 2), 5'($urandom)});
            idle(int'($urandom_range(0, 3)));
        end
    endtask

    // Monitor: every done/error pulse must match the oldest prediction.
    always @(negedge clk) begin
        ev_t e;
        if (frame_done === 1'b1 && frame_error === 1'b1)
            check("done_and_error_together", 128'(1), 128'(0));
        if (frame_done === 1'b1 || frame_error === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 128'({frame_done, frame_error}), 128'(0));
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", 128'({frame_done, frame_error}), 128'({!e.is_err, e.is_err}));
                check("pulse_cycle", 128'(n), 128'(e.cyc));
                check("pulse_code", 128'(LEDG[6:4]), 128'(e.code));
                check("pulse_board", 128'(board), 128'(e.brd));
            end
        end
        if (exp_q.size() > 0 && exp_q[0].cyc < n) begin
            e = exp_q.pop_front();
            check("missing_pulse", 128'(0), 128'(e.cyc));
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        check("reset_done", 128'(frame_done), 128'(0));
        check("reset_error", 128'(frame_error), 128'(0));

        // Happy path with the row pattern
        step(0, 1, 0, 8'h00);
        send_pattern_frame();
        idle(3);
        for (int r = 0; r < 10; r++) begin
            logic [4:0] rv;
            rv = 5'(r);
            check("pattern_row", 128'(board[r*10 +: 10]), 128'({~rv, rv}));
        end
        check("pattern_row_count", 128'(row_count), 128'(10));

        // Bad tag
        step(0, 1, 0, 8'h00);
        send(8'h81);
        send(8'h41);
        idle(3);
        check("badtag_code", 128'(LEDG[6:4]), 128'(1));

        // Half order, then recovery with a random frame
        step(0, 1, 0, 8'h00);
        send(8'hA3);
        idle(2);
        check("half_code", 128'(LEDG[6:4]), 128'(2));
        step(0, 1, 0, 8'h00);
        send_random_frame();
        idle(2);

        // Timeout after three bytes
        step(0, 1, 0, 8'h00);
        send(8'h81); send(8'hA2); send(8'h83);
        idle(TMO + 5);
        check("timeout_code", 128'(LEDG[6:4]), 128'(3));

        // Byte on the very cycle the timeout would fire is accepted
        step(0, 1, 0, 8'h00);
        send(8'h81); send(8'hA2); send(8'h83);
        idle(TMO - 1);
        send(8'hA4);
        idle(TMO + 5);

        // Byte one cycle earlier
        step(0, 1, 0, 8'h00);
        send(8'h85);
        idle(TMO - 2);
        send(8'hA6);
        idle(5);

        // Restart mid-frame with a simultaneous byte
        step(0, 1, 0, 8'h00);
        for (int b = 0; b < 8; b++) send({2'b10, 1'(b % 2), 5'(b)});
        check("restart_pre_rows", 128'(row_count), 128'(4));
        step(0, 1, 1, 8'h85);
        check("restart_rows", 128'(row_count), 128'(0));
        send_random_frame();
        idle(2);

        // Reset mid-frame, then bytes while idle
        step(0, 1, 0, 8'h00);
        for (int b = 0; b < 7; b++) send({2'b10, 1'(b % 2), 5'($urandom)});
        step(1, 0, 0, 8'h00);
        for (int b = 0; b < 6; b++) send({2'b10, 1'(b % 2), 5'($urandom)});
        check("reset_board_zero", 128'(board), 128'(0));

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            int p;
            logic [7:0] d;
            p = int'($urandom_range(0, 999));
            if (p < 5) begin
                step(1, 0, 0, 8'h00);
            end else if (p < 30) begin
                step(0, 1, $urandom_range(0, 1) == 1, 8'($urandom));
            end else if (p < 33) begin
                idle(int'($urandom_range(TMO - 2, TMO + 3)));
            end else if (p < 600) begin
                int q;
                q = int'($urandom_range(0, 99));
                if (q < 2)      d = {2'($urandom_range(0, 2) == 2 ? 2'b11 : 2'($urandom_range(0, 1))), 6'($urandom)};
                else if (q < 4) d = {2'b10, 1'((m_bytes % 2) == 0), 5'($urandom)};
                else            d = {2'b10, 1'(m_bytes % 2), 5'($urandom)};
                send(d);
            end else begin
                step(0, 0, 0, 8'($urandom));
            end
        end
        idle(3);

        check("queue_empty", 128'(exp_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
